// File: rtl/user_pkt_pkg.sv
// Shared types and constants for the user packet generator.
// Holds FSM state encoding, EOP byte-enable codes and frame length limits.
package user_pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Valid-byte codes for the EOP word.
    localparam logic [1:0] BE_4 = 2'b00;
    localparam logic [1:0] BE_1 = 2'b01;
    localparam logic [1:0] BE_2 = 2'b10;
    localparam logic [1:0] BE_3 = 2'b11;

    localparam logic [10:0] MIN_LEN = 11'd60;
    localparam logic [10:0] MAX_LEN = 11'd1514;

    function automatic logic [10:0] clamp_len(input logic [10:0] len);
        if (len < MIN_LEN)
            return MIN_LEN;
        else if (len > MAX_LEN)
            return MAX_LEN;
        else
            return len;
    endfunction

    function automatic logic [1:0] eop_be(input logic [10:0] len);
        logic [1:0] be;
        unique case (len[1:0])
            2'd0:    be = BE_4;
            2'd1:    be = BE_1;
            2'd2:    be = BE_2;
            default: be = BE_3;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/user_pkt_if.sv
// MAC user TX FIFO write bundle.
// Ports: wa (FIFO write-allowed), wr, data, be, sop, eop (write side).
interface user_pkt_if;

    logic        wa;
    logic        wr;
    logic [31:0] data;
    logic [1:0]  be;
    logic        sop;
    logic        eop;

    modport master (
        input  wa,
        output wr, data, be, sop, eop
    );

    modport slave (
        output wa,
        input  wr, data, be, sop, eop
    );

endinterface

// File: rtl/user_pkt_word.sv
// Combinational frame word builder: 4 bytes starting at byte offset off_i.
// Ports: off_i (byte offset), len_i (frame length), da_i/sa_i (MACs), word_o.
module user_pkt_word (
    input  logic [10:0] off_i,
    input  logic [10:0] len_i,
    input  logic [47:0] da_i,
    input  logic [47:0] sa_i,
    output logic [31:0] word_o
);

    import user_pkt_pkg::*;

    function automatic logic [7:0] byte_at(
        input logic [10:0] k,
        input logic [10:0] len,
        input logic [47:0] da,
        input logic [47:0] sa
    );
        logic [15:0] lf;
        logic [7:0]  b;
        lf = {5'd0, len} - 16'd14;
        if (k >= len)
            b = 8'd0;
        else if (k < 11'd6)
            b = 8'(da >> (8 * (5 - int'(k))));
        else if (k < 11'd12)
            b = 8'(sa >> (8 * (11 - int'(k))));
        else if (k == 11'd12)
            b = lf[15:8];
        else if (k == 11'd13)
            b = lf[7:0];
        else
            b = 8'(int'(k) - 14);
        return b;
    endfunction

    // Byte offset 0 of the word lands in bits 31:24.
    always_comb begin
        word_o = '0;
        for (int b = 0; b < 4; b++) begin
            word_o[8*(3-b) +: 8] =
                byte_at(off_i + 11'(b), len_i, da_i, sa_i);
        end
    end

endmodule

// File: rtl/user_pkt_gen.sv
// Ethernet test-frame burst generator feeding the MAC user TX FIFO.
// Ports: Clk_user/Reset_n, Start/Stop/Pkt_len/Pkt_num, Tx_mac_*, Busy/Pkt_cnt.
module user_pkt_gen #(
    parameter logic [47:0] DA      = 48'h0010_A4C0_1122,
    parameter logic [47:0] SA      = 48'h0010_A4C0_3344,
    parameter int unsigned IFG_CYC = 4
) (
    input  logic        Clk_user,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Stop,
    input  logic [10:0] Pkt_len,
    input  logic [15:0] Pkt_num,
    input  logic        Tx_mac_wa,
    output logic        Tx_mac_wr,
    output logic [31:0] Tx_mac_data,
    output logic [1:0]  Tx_mac_BE,
    output logic        Tx_mac_sop,
    output logic        Tx_mac_eop,
    output logic        Busy,
    output logic [15:0] Pkt_cnt
);

    import user_pkt_pkg::*;

    localparam logic [7:0] GAP_LOAD =
        (IFG_CYC == 0) ? 8'd0 : 8'(IFG_CYC - 1);

    state_t      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic [15:0] left_q, left_d;
    logic        cont_q, cont_d;
    logic        stop_q, stop_d;
    logic [10:0] off_q, off_d;
    logic [7:0]  gap_q, gap_d;
    logic        wr_q, wr_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic [31:0] word_w;
    logic        last_w;

    user_pkt_word u_word (
        .off_i  (off_q),
        .len_i  (len_q),
        .da_i   (DA),
        .sa_i   (SA),
        .word_o (word_w)
    );

    assign last_w = ({1'b0, off_q} + 12'd4) >= {1'b0, len_q};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        left_d  = left_q;
        cont_d  = cont_q;
        stop_d  = stop_q;
        off_d   = off_q;
        gap_d   = gap_q;
        wr_d    = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        data_d  = data_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    len_d   = clamp_len(Pkt_len);
                    left_d  = Pkt_num;
                    cont_d  = (Pkt_num == 16'd0);
                    stop_d  = 1'b0;
                    off_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                stop_d = stop_q | Stop;
                // wa is consumed here so the write lands one cycle later.
                if (Tx_mac_wa) begin
                    wr_d   = 1'b1;
                    sop_d  = (off_q == '0);
                    eop_d  = last_w;
                    data_d = word_w;
                    be_d   = last_w ? eop_be(len_q) : BE_4;
                    off_d  = off_q + 11'd4;
                    if (last_w) begin
                        off_d  = '0;
                        cnt_d  = cnt_q + 16'd1;
                        left_d = left_q - 16'd1;
                        if (stop_d || (!cont_q && left_q == 16'd1)) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end else if (IFG_CYC == 0) begin
                            state_d = ST_SEND;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (Stop || stop_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (gap_q == 8'd0) begin
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk_user or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            left_q  <= '0;
            cont_q  <= 1'b0;
            stop_q  <= 1'b0;
            off_q   <= '0;
            gap_q   <= '0;
            wr_q    <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            left_q  <= left_d;
            cont_q  <= cont_d;
            stop_q  <= stop_d;
            off_q   <= off_d;
            gap_q   <= gap_d;
            wr_q    <= wr_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign Tx_mac_wr   = wr_q;
    assign Tx_mac_data = data_q;
    assign Tx_mac_BE   = be_q;
    assign Tx_mac_sop  = sop_q;
    assign Tx_mac_eop  = eop_q;
    assign Busy        = busy_q;
    assign Pkt_cnt     = cnt_q;

endmodule

// File: tb/tb_user_pkt_gen.sv
// Self-checking bench for user_pkt_gen.
// Frames are compared against a byte-level model built from the frame rules.
module tb_user_pkt_gen;

    localparam logic [47:0] DA = 48'h0010_A4C0_1122;
    localparam logic [47:0] SA = 48'h0010_A4C0_3344;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  be;
        logic        sop;
        logic        eop;
        int          cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [10:0] pkt_len = '0;
    logic [15:0] pkt_num = '0;
    logic        busy;
    logic [15:0] pkt_cnt;

    user_pkt_if tx_if ();

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wa_viol = 0;
    logic wa_last = 1'b0;

    rec_t cap[$];
    rec_t exp_q[$];

    user_pkt_gen dut (
        .Clk_user    (clk),
        .Reset_n     (rst_n),
        .Start       (start),
        .Stop        (stop),
        .Pkt_len     (pkt_len),
        .Pkt_num     (pkt_num),
        .Tx_mac_wa   (tx_if.wa),
        .Tx_mac_wr   (tx_if.wr),
        .Tx_mac_data (tx_if.data),
        .Tx_mac_BE   (tx_if.be),
        .Tx_mac_sop  (tx_if.sop),
        .Tx_mac_eop  (tx_if.eop),
        .Busy        (busy),
        .Pkt_cnt     (pkt_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && tx_if.wr) begin
            cap.push_back('{tx_if.data, tx_if.be, tx_if.sop,
                            tx_if.eop, cyc});
            if (!wa_last) wa_viol++;
        end
        wa_last = tx_if.wa;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic make_exp(input int len_in, input int nf);
        int L;
        int nw;
        rec_t r;
        logic [7:0] bt;
        logic [31:0] w;
        logic [47:0] da_v;
        logic [47:0] sa_v;
        da_v = DA;
        sa_v = SA;
        L = (len_in < 60) ? 60 : (len_in > 1514) ? 1514 : len_in;
        nw = (L + 3) / 4;
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < nw; i++) begin
                w = '0;
                for (int b = 0; b < 4; b++) begin
                    int k;
                    k = 4 * i + b;
                    if (k >= L) bt = 8'd0;
                    else if (k < 6) bt = da_v[8*(5-k) +: 8];
                    else if (k < 12) bt = sa_v[8*(11-k) +: 8];
                    else if (k == 12) bt = 8'((L - 14) / 256);
                    else if (k == 13) bt = 8'((L - 14) % 256);
                    else bt = 8'((k - 14) % 256);
                    w[31-8*b -: 8] = bt;
                end
                r.d = w;
                r.be = (i == nw - 1) ? 2'(L % 4) : 2'b00;
                r.sop = (i == 0);
                r.eop = (i == nw - 1);
                r.cyc = 0;
                exp_q.push_back(r);
            end
        end
    endtask

    function automatic int count_diff();
        int n;
        int m;
        n = 0;
        m = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            if (cap[i].d !== exp_q[i].d || cap[i].be !== exp_q[i].be ||
                cap[i].sop !== exp_q[i].sop || cap[i].eop !== exp_q[i].eop)
                n++;
        end
        return n;
    endfunction

    task automatic start_burst(input int len, input int num, output int s);
        @(posedge clk) #1;
        pkt_len = 11'(len);
        pkt_num = 16'(num);
        start = 1'b1;
        s = cyc;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        tx_if.wa = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_if.wr, tx_if.sop, tx_if.eop} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 000",
                     {tx_if.wr, tx_if.sop, tx_if.eop});
        end
        checks++;
        if (tx_if.data !== 32'h0 || tx_if.be !== 2'b00) begin
            errors++;
            $display("FAIL reset_data: got %h/%b want 0/00",
                     tx_if.data, tx_if.be);
        end
        checks++;
        if (busy !== 1'b0 || pkt_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b cnt=%0d want 0/0",
                     busy, pkt_cnt);
        end
        @(posedge clk) #1;
        rst_n = 1'b1;
        tx_if.wa = 1'b1;
        cap.delete();
        @(posedge clk) #1;
        stop = 1'b1;
        @(posedge clk) #1;
        stop = 1'b0;
        repeat (6) @(negedge clk);
        n = cap.size();
        checks++;
        if (n !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_stop: got writes=%0d busy=%b want 0/0",
                     n, busy);
        end
    endtask

    task automatic test_min_frame();
        int s;
        bit ok;
        int n;
        cap.delete();
        exp_q.delete();
        tx_if.wa = 1'b1;
        make_exp(60, 1);
        start_burst(60, 1, s);
        wait_idle(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL min_timeout: got busy stuck want idle");
        end
        checks++;
        if (cap.size() !== 15) begin
            errors++;
            $display("FAIL min_count: got %0d want 15", cap.size());
        end
        n = count_diff();
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL min_words: got %0d bad words want 0", n);
        end
        checks++;
        if (cap.size() < 15 || cap[0].d !== 32'h0010A4C0 ||
            cap[3].d !== 32'h002E0001) begin
            errors++;
            $display("FAIL min_w0w3: got %h/%h want 0010a4c0/002e0001",
                     cap.size() > 0 ? cap[0].d : 32'hx,
                     cap.size() > 3 ? cap[3].d : 32'hx);
        end
        checks++;
        if (cap.size() < 15 || cap[14].be !== 2'b00 || !cap[14].eop) begin
            errors++;
            $display("FAIL min_eop_be: got be/eop wrong want 00/1");
        end
        checks++;
        if (cap.size() < 1 || cap[0].cyc < s + 2 || !cap[0].sop) begin
            errors++;
            $display("FAIL min_sop_lat: got cyc=%0d want >=%0d with sop",
                     cap.size() > 0 ? cap[0].cyc : -1, s + 2);
        end
        checks++;
        if (pkt_cnt !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL min_status: got cnt=%0d busy=%b want 1/0",
                     pkt_cnt, busy);
        end
    endtask

    task automatic test_ifg();
        int s;
        bit ok;
        int n;
        int gap;
        cap.delete();
        exp_q.delete();
        tx_if.wa = 1'b1;
        make_exp(61, 2);
        start_burst(61, 2, s);
        wait_idle(300, ok);
        n = count_diff();
        checks++;
        if (!ok || cap.size() !== 32 || n !== 0) begin
            errors++;
            $display("FAIL ifg_frames: got ok=%0d n=%0d bad=%0d want 1/32/0",
                     ok, cap.size(), n);
        end
        checks++;
        if (cap.size() < 16 || cap[15].be !== 2'b01 ||
            cap[15].d !== 32'h2E000000) begin
            errors++;
            $display("FAIL ifg_eop: got wrong eop word want 2e000000/01");
        end
        gap = (cap.size() >= 17) ? cap[16].cyc - cap[15].cyc - 1 : -1;
        checks++;
        if (gap !== 4) begin
            errors++;
            $display("FAIL ifg_gap: got %0d idle cycles want 4", gap);
        end
        checks++;
        if (pkt_cnt !== 16'd2) begin
            errors++;
            $display("FAIL ifg_cnt: got %0d want 2", pkt_cnt);
        end
    endtask

    task automatic test_stall();
        int s;
        bit ok;
        int n;
        int c0;
        int in_win;
        int after;
        cap.delete();
        exp_q.delete();
        tx_if.wa = 1'b1;
        make_exp(100, 1);
        start_burst(100, 1, s);
        repeat (4) @(posedge clk);
        #1;
        tx_if.wa = 1'b0;
        c0 = cyc;
        repeat (5) @(posedge clk);
        #1;
        tx_if.wa = 1'b1;
        wait_idle(300, ok);
        in_win = 0;
        after = 0;
        foreach (cap[i]) begin
            if (cap[i].cyc >= c0 + 1 && cap[i].cyc <= c0 + 5) in_win++;
            if (cap[i].cyc > c0 + 5) after++;
        end
        n = count_diff();
        checks++;
        if (!ok || cap.size() !== 25 || n !== 0) begin
            errors++;
            $display("FAIL stall_frame: got ok=%0d n=%0d bad=%0d want 1/25/0",
                     ok, cap.size(), n);
        end
        checks++;
        if (in_win !== 0 || after == 0) begin
            errors++;
            $display("FAIL stall_window: got %0d writes in stall want 0",
                     in_win);
        end
        checks++;
        if (wa_viol !== 0) begin
            errors++;
            $display("FAIL stall_wa: got %0d writes without wa want 0",
                     wa_viol);
        end
    endtask

    task automatic test_stop();
        int s;
        bit ok;
        bit seen;
        int n;
        cap.delete();
        exp_q.delete();
        tx_if.wa = 1'b1;
        make_exp(60, 3);
        start_burst(60, 0, s);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cap.size() >= 40) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk) #1;
        stop = 1'b1;
        @(posedge clk) #1;
        stop = 1'b0;
        wait_idle(300, ok);
        n = count_diff();
        checks++;
        if (!seen || !ok || cap.size() !== 45 || n !== 0) begin
            errors++;
            $display("FAIL stop_frames: got n=%0d bad=%0d want 45/0",
                     cap.size(), n);
        end
        checks++;
        if (pkt_cnt !== 16'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_status: got cnt=%0d busy=%b want 3/0",
                     pkt_cnt, busy);
        end
    endtask

    task automatic test_max();
        int s;
        bit ok;
        int n;
        cap.delete();
        exp_q.delete();
        tx_if.wa = 1'b1;
        make_exp(2000, 1);
        start_burst(2000, 1, s);
        wait_idle(1000, ok);
        n = count_diff();
        checks++;
        if (!ok || cap.size() !== 379 || n !== 0) begin
            errors++;
            $display("FAIL max_frame: got n=%0d bad=%0d want 379/0",
                     cap.size(), n);
        end
        checks++;
        if (cap.size() < 379 || cap[378].be !== 2'b10 ||
            cap[3].d[31:16] !== 16'h05DC) begin
            errors++;
            $display("FAIL max_fields: got be/len wrong want 10/05dc");
        end
    endtask

    task automatic test_reset_mid();
        int s;
        bit ok;
        int n;
        cap.delete();
        exp_q.delete();
        tx_if.wa = 1'b1;
        start_burst(100, 1, s);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cap.size() >= 7) break;
        end
        @(posedge clk) #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_if.wr, tx_if.sop, tx_if.eop, tx_if.be, busy} !== 6'b0 ||
            tx_if.data !== 32'h0 || pkt_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got wr=%b data=%h busy=%b want 0",
                     tx_if.wr, tx_if.data, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cap.delete();
        repeat (10) @(negedge clk);
        n = cap.size();
        checks++;
        if (n !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_resume: got writes=%0d want 0", n);
        end
        make_exp(60, 1);
        start_burst(60, 1, s);
        @(negedge clk);
        checks++;
        if (pkt_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_cnt0: got %0d want 0", pkt_cnt);
        end
        wait_idle(200, ok);
        n = count_diff();
        checks++;
        if (!ok || cap.size() !== 15 || n !== 0 || pkt_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_restart: got n=%0d bad=%0d cnt=%0d want 15/0/1",
                     cap.size(), n, pkt_cnt);
        end
    endtask

    task automatic test_random();
        int len;
        int num;
        int s;
        int n;
        bit done;
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(0, 2047);
            num = $urandom_range(1, 3);
            cap.delete();
            exp_q.delete();
            make_exp(len, num);
            start_burst(len, num, s);
            done = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                @(posedge clk) #1;
                tx_if.wa = ($urandom_range(0, 3) != 0);
                if (i == 3) begin
                    pkt_len = 11'($urandom_range(0, 2047));
                    pkt_num = 16'd7;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                if (i > 4 && !busy) begin
                    done = 1'b1;
                    break;
                end
            end
            start = 1'b0;
            tx_if.wa = 1'b1;
            repeat (3) @(negedge clk);
            n = count_diff();
            checks++;
            if (!done || cap.size() !== exp_q.size() || n !== 0) begin
                errors++;
                $display("FAIL rand_frames[%0d]: len=%0d got n=%0d bad=%0d want %0d/0",
                         it, len, cap.size(), n, exp_q.size());
            end
            checks++;
            if (pkt_cnt !== 16'(num)) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %0d want %0d",
                         it, pkt_cnt, num);
            end
        end
        checks++;
        if (wa_viol !== 0) begin
            errors++;
            $display("FAIL rand_wa: got %0d writes without wa want 0",
                     wa_viol);
        end
    endtask

    initial begin
        tx_if.wa = 1'b0;
        test_reset();
        test_min_frame();
        test_ifg();
        test_stall();
        test_stop();
        test_max();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/user_pkt_gen.md
USER_PKT_GEN -- requirements
Module: user_pkt_gen

Interface
REQ-001 SHALL have parameter DA, default 48'h0010_A4C0_1122, destination MAC placed in every frame.
REQ-002 SHALL have parameter SA, default 48'h0010_A4C0_3344, source MAC placed in every frame.
REQ-003 SHALL have parameter IFG_CYC, default 4, idle cycles between frame EOP and next SOP (range 0..255).
REQ-004 SHALL have port Clk_user, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port Start, input, 1, one-cycle pulse starting a frame burst.
REQ-007 SHALL have port Stop, input, 1, pulse ending a burst after the current frame.
REQ-008 SHALL have port Pkt_len, input, 11, frame length in bytes excluding FCS; sampled on Start.
REQ-009 SHALL have port Pkt_num, input, 16, frames per burst; 0 means continuous until Stop; sampled on Start.
REQ-010 SHALL have port Tx_mac_wa, input, 1, MAC user FIFO write-allowed.
REQ-011 SHALL have port Tx_mac_wr, output, 1, word write strobe.
REQ-012 SHALL have port Tx_mac_data, output, 32, frame word, lowest byte offset in bits 31:24.
REQ-013 SHALL have port Tx_mac_BE, output, 2, valid bytes in EOP word: 00=4, 01=1, 10=2, 11=3.
REQ-014 SHALL have ports Tx_mac_sop and Tx_mac_eop, output, 1 each, first/last word markers, qualified by Tx_mac_wr.
REQ-015 SHALL have port Busy, output, 1, high from Start acceptance until burst end.
REQ-016 SHALL have port Pkt_cnt, output, 16, frames fully sent (EOP written) since last Start.

Function
REQ-017 SHALL implement states IDLE, SEND, GAP; IDLE->SEND on Start; SEND->GAP on EOP write; GAP->SEND after IFG_CYC cycles if frames remain and no Stop pending, else ->IDLE.
REQ-018 SHALL clamp latched length L to 60 if Pkt_len<60 and to 1514 if Pkt_len>1514.
REQ-019 SHALL emit ceil(L/4) words per frame: bytes 0-5 DA, 6-11 SA, 12-13 L-14 big-endian, byte k>=14 equal to (k-14) mod 256.
REQ-020 SHALL set Tx_mac_BE to 00 on non-EOP words and to L mod 4 encoding on the EOP word; bytes beyond L zero.
REQ-021 SHALL register all outputs; Tx_mac_wr asserted in cycle N only if Tx_mac_wa was high in cycle N-1; data held while wa low.
REQ-022 SHALL assert first SOP write no earlier than 2 cycles after the Start cycle.
REQ-023 SHALL ignore Start while Busy; Stop in IDLE has no effect; Stop mid-frame completes the frame, skips GAP, then IDLE.
REQ-024 SHALL clear Pkt_cnt on accepted Start and increment it on each EOP write, wrapping 0xFFFF->0.
REQ-025 SHALL drive Tx_mac_wr, sop, eop low in GAP and IDLE; with IFG_CYC=0 the next SOP follows EOP directly (wa permitting).

Reset
REQ-026 SHALL, on Reset_n low, immediately force state IDLE, all outputs 0, counters 0, regardless of frame in progress.
REQ-027 SHALL resume only on a new Start after Reset_n deasserts; no partial frame continuation.

Structure
REQ-028 SHALL place state encoding, BE encodings, MIN_LEN=60, MAX_LEN=1514 in shared package user_pkt_pkg.
REQ-029 SHALL use one sub-module user_pkt_word: combinational word builder from byte offset, L, DA, SA.

Verification
REQ-030 Start, Pkt_len=60, Pkt_num=1, wa=1 -> 15 writes, word0=0x0010A4C0, word3=0x002E0001, EOP BE=00, Pkt_cnt=1, Busy low after.
REQ-031 Pkt_len=61, Pkt_num=2, IFG_CYC=4 -> 16 words/frame, EOP BE=01 data 0x2E000000, exactly 4 idle cycles between frames.
REQ-032 Pkt_len=100, wa low cycles 5-9 of frame -> no writes during stall+1, no lost/duplicated words, 25 words total.
REQ-033 Pkt_num=0, Stop at word 10 of frame 3 -> frame 3 completes, IDLE, Pkt_cnt=3.
REQ-034 Pkt_len=2000 -> 1514-byte frame, 379 words, EOP BE=10, length field 0x05DC.
REQ-035 Reset_n low mid-frame word 7 -> all outputs 0 same cycle; second Start restarts at SOP with Pkt_cnt=0.
